// File: rtl/boid_xcel_ctrl.sv
// Frame sequencer for the boid update datapath: per boid it clears the accumulators,
// loads own state, streams all boids as neighbours, then writes the result to the other bank.
module boid_xcel_ctrl #(
    parameter int N_BOIDS = 32,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              acc_clr,
    output logic              r_en_tot,
    output logic              r_en_itr,
    output logic [6:0]        wb_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_ITER,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BOIDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic              rd_bank_q, rd_bank_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        rd_bank_d = rd_bank_q;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        acc_clr   = 1'b0;
        r_en_tot  = 1'b0;
        r_en_itr  = 1'b0;
        wb_en     = 7'b0000000;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                acc_clr = 1'b1;
                rd_en   = 1'b1;
                rd_addr = i_q;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // Own-boid data arrives now; issue the first neighbour read in the same cycle.
                r_en_tot = 1'b1;
                rd_en    = 1'b1;
                rd_addr  = '0;
                j_d      = '0;
                state_d  = S_ITER;
            end
            S_ITER: begin
                // j_q names the neighbour whose data is on the bus; the self slot is skipped.
                r_en_itr = (j_q != i_q);
                if (j_q != LAST_IDX) begin
                    rd_en   = 1'b1;
                    rd_addr = j_q + 1'b1;
                    j_d     = j_q + 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_en   = 7'b0000001;
                wr_en   = 1'b1;
                wr_addr = i_q;
                if (i_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                rd_bank_d = ~rd_bank_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign rd_bank = rd_bank_q;

endmodule

// File: tb/tb_boid_xcel_ctrl.sv
// Scoreboard bench for boid_xcel_ctrl: a 4-boid instance for cycle-exact checks and a
// 32-boid instance for frame length and strobe counts.
module tb_boid_xcel_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start4, start32;

    logic       busy4, done4, rd_en4, rd_bank4, wr_en4, acc_clr4, r_en_tot4, r_en_itr4;
    logic [1:0] rd_addr4, wr_addr4;
    logic [6:0] wb_en4;

    logic       busy32, done32, rd_en32, rd_bank32, wr_en32, acc_clr32, r_en_tot32, r_en_itr32;
    logic [5:0] rd_addr32, wr_addr32;
    logic [6:0] wb_en32;

    int checks   = 0;
    int failures = 0;
    logic exp_bank = 1'b0;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    boid_xcel_ctrl #(.N_BOIDS(4), .ADDR_W(2)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_bank(rd_bank4), .wr_en(wr_en4), .wr_addr(wr_addr4),
        .acc_clr(acc_clr4), .r_en_tot(r_en_tot4), .r_en_itr(r_en_itr4), .wb_en(wb_en4)
    );

    boid_xcel_ctrl #(.N_BOIDS(32), .ADDR_W(6)) dut32 (
        .clk(clk), .reset(reset), .start(start32),
        .busy(busy32), .done(done32), .rd_en(rd_en32), .rd_addr(rd_addr32),
        .rd_bank(rd_bank32), .wr_en(wr_en32), .wr_addr(wr_addr32),
        .acc_clr(acc_clr32), .r_en_tot(r_en_tot32), .r_en_itr(r_en_itr32), .wb_en(wb_en32)
    );

    function automatic logic [18:0] outs4();
        return {busy4, done4, rd_en4, rd_addr4, rd_bank4, wr_en4, wr_addr4,
                acc_clr4, r_en_tot4, r_en_itr4, wb_en4};
    endfunction

    function automatic logic [26:0] outs32();
        return {busy32, done32, rd_en32, rd_addr32, rd_bank32, wr_en32, wr_addr32,
                acc_clr32, r_en_tot32, r_en_itr32, wb_en32};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start4 = 1'b0; start32 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs4() !== '0) begin
            failures++;
            $display("FAIL reset_outs4 got=%h want=0", outs4());
        end
        checks++;
        if (outs32() !== '0) begin
            failures++;
            $display("FAIL reset_outs32 got=%h want=0", outs32());
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs4() !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h want=0", outs4());
        end
        $display("test_reset done");
    endtask

    // One start pulse at cycle 0; optional extra start pulse mid-frame (0 = none).
    task automatic test_frame(input int mid_start);
        ev_t wr_q[$];
        int  clr_q[$];
        ev_t rd2_q[$];
        ev_t e;
        int  tot_cnt = 0;
        int  itr_cnt = 0;
        int  addrs2[5] = '{2, 0, 1, 2, 3};
        for (int k = 0; k < 4; k++) begin
            wr_q.push_back('{cyc: 7 + 7 * k, addr: k});
            clr_q.push_back(1 + 7 * k);
        end
        for (int k = 0; k < 5; k++) rd2_q.push_back('{cyc: 15 + k, addr: addrs2[k]});

        @(negedge clk);
        start4 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start4 = 1'b0;
            if (c == mid_start) start4 = 1'b1;
            if (c == mid_start + 1) start4 = 1'b0;

            checks++;
            if (busy4 !== (c <= 29)) begin
                failures++;
                $display("FAIL frame_busy cyc=%0d got=%b want=%b", c, busy4, (c <= 29));
            end
            checks++;
            if (done4 !== (c == 29)) begin
                failures++;
                $display("FAIL frame_done cyc=%0d got=%b want=%b", c, done4, (c == 29));
            end
            checks++;
            if (rd_bank4 !== ((c <= 29) ? exp_bank : ~exp_bank)) begin
                failures++;
                $display("FAIL frame_rd_bank cyc=%0d got=%b", c, rd_bank4);
            end
            if (wr_en4) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_wr_unexpected cyc=%0d addr=%0d", c, wr_addr4);
                end else begin
                    e = wr_q.pop_front();
                    if (c != e.cyc || int'(wr_addr4) != e.addr || wb_en4 !== 7'd1) begin
                        failures++;
                        $display("FAIL frame_wr cyc=%0d addr=%0d wb=%b want cyc=%0d addr=%0d wb=1",
                                 c, wr_addr4, wb_en4, e.cyc, e.addr);
                    end
                end
            end
            if (acc_clr4) begin
                checks++;
                if (clr_q.size() == 0 || clr_q[0] != c) begin
                    failures++;
                    $display("FAIL frame_acc_clr cyc=%0d want=%0d", c,
                             (clr_q.size() == 0) ? -1 : clr_q[0]);
                end
                if (clr_q.size() != 0) void'(clr_q.pop_front());
            end
            if (c >= 15 && c <= 21 && rd_en4) begin
                checks++;
                if (rd2_q.size() == 0) begin
                    failures++;
                    $display("FAIL boid2_rd_unexpected cyc=%0d addr=%0d", c, rd_addr4);
                end else begin
                    e = rd2_q.pop_front();
                    if (c != e.cyc || int'(rd_addr4) != e.addr) begin
                        failures++;
                        $display("FAIL boid2_rd cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                                 c, rd_addr4, e.cyc, e.addr);
                    end
                end
            end
            if (c >= 15 && c <= 21 && r_en_tot4) begin
                tot_cnt++;
                checks++;
                if (c != 16) begin
                    failures++;
                    $display("FAIL boid2_tot_cycle got=%0d want=16", c);
                end
            end
            if (c >= 15 && c <= 21 && r_en_itr4) itr_cnt++;
            if (c == 19) begin
                checks++;
                if (r_en_itr4 !== 1'b0) begin
                    failures++;
                    $display("FAIL boid2_self_slot got=%b want=0", r_en_itr4);
                end
            end
            if (r_en_tot4 && r_en_itr4) begin
                checks++;
                failures++;
                $display("FAIL tot_itr_overlap cyc=%0d got=1 want=0", c);
            end
        end
        checks++;
        if (wr_q.size() != 0 || clr_q.size() != 0 || rd2_q.size() != 0) begin
            failures++;
            $display("FAIL frame_missing wr=%0d clr=%0d rd=%0d want=0 0 0",
                     wr_q.size(), clr_q.size(), rd2_q.size());
        end
        checks++;
        if (tot_cnt != 1 || itr_cnt != 3) begin
            failures++;
            $display("FAIL boid2_counts tot=%0d itr=%0d want tot=1 itr=3", tot_cnt, itr_cnt);
        end
        exp_bank = ~exp_bank;
        $display("test_frame mid_start=%0d done", mid_start);
    endtask

    task automatic test_back_to_back();
        ev_t wr_q[$];
        ev_t e;
        logic b0 = exp_bank;
        logic eb;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 4; k++) wr_q.push_back('{cyc: 30 * f + 7 + 7 * k, addr: k});

        @(negedge clk);
        start4 = 1'b1;
        for (int c = 1; c <= 65; c++) begin
            @(negedge clk);
            if (c == 50) start4 = 1'b0;
            checks++;
            if (busy4 !== ((c >= 1 && c <= 29) || (c >= 31 && c <= 59))) begin
                failures++;
                $display("FAIL b2b_busy cyc=%0d got=%b", c, busy4);
            end
            checks++;
            if (done4 !== (c == 29 || c == 59)) begin
                failures++;
                $display("FAIL b2b_done cyc=%0d got=%b", c, done4);
            end
            eb = (c >= 30 && c <= 59) ? ~b0 : b0;
            checks++;
            if (rd_bank4 !== eb) begin
                failures++;
                $display("FAIL b2b_rd_bank cyc=%0d got=%b want=%b", c, rd_bank4, eb);
            end
            if (wr_en4) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_wr_unexpected cyc=%0d", c);
                end else begin
                    e = wr_q.pop_front();
                    if (c != e.cyc || int'(wr_addr4) != e.addr) begin
                        failures++;
                        $display("FAIL b2b_wr cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                                 c, wr_addr4, e.cyc, e.addr);
                    end
                end
            end
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_wr_missing got=%0d want=0", wr_q.size());
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        logic bank_before;
        @(negedge clk);
        start4 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start4 = 1'b0;
        end
        checks++;
        if (r_en_itr4 !== 1'b1 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_iter itr=%b busy=%b want=1 1", r_en_itr4, busy4);
        end
        bank_before = rd_bank4;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs4() !== '0) begin
            failures++;
            $display("FAIL rstmid_outs got=%h want=0", outs4());
        end
        checks++;
        if (rd_bank4 !== bank_before) begin
            failures++;
            $display("FAIL rstmid_bank got=%b want=%b", rd_bank4, bank_before);
        end
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_en4 || busy4) begin
                checks++;
                failures++;
                $display("FAIL rstmid_activity cyc=%0d wr_en=%b busy=%b want=0 0", c, wr_en4, busy4);
            end
        end
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b want=0", busy4);
        end
        exp_bank = 1'b0;
        $display("test_reset_mid done");
    endtask

    task automatic test_big();
        int wr_q[$];
        int wr_cnt = 0;
        int itr_cnt = 0;
        int done_cyc = -1;
        for (int k = 0; k < 32; k++) wr_q.push_back(k);
        @(negedge clk);
        start32 = 1'b1;
        for (int c = 1; c <= 1200 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) start32 = 1'b0;
            if (r_en_itr32) itr_cnt++;
            if (wr_en32) begin
                wr_cnt++;
                checks++;
                if (wr_q.size() == 0 || int'(wr_addr32) != wr_q[0]) begin
                    failures++;
                    $display("FAIL big_wr_addr cyc=%0d got=%0d want=%0d", c, wr_addr32,
                             (wr_q.size() == 0) ? -1 : wr_q[0]);
                end
                if (wr_q.size() != 0) void'(wr_q.pop_front());
            end
            if (done32) done_cyc = c;
        end
        checks++;
        if (done_cyc != 1121) begin
            failures++;
            $display("FAIL big_done_cycle got=%0d want=1121", done_cyc);
        end
        checks++;
        if (wr_cnt != 32) begin
            failures++;
            $display("FAIL big_wr_count got=%0d want=32", wr_cnt);
        end
        checks++;
        if (itr_cnt != 992) begin
            failures++;
            $display("FAIL big_itr_count got=%0d want=992", itr_cnt);
        end
        @(negedge clk);
        checks++;
        if (busy32 !== 1'b0 || rd_bank32 !== 1'b1) begin
            failures++;
            $display("FAIL big_after busy=%b bank=%b want=0 1", busy32, rd_bank32);
        end
        $display("test_big done_cycle=%0d wr=%0d itr=%0d", done_cyc, wr_cnt, itr_cnt);
    endtask

    initial begin
        reset = 1'b1;
        start4 = 1'b0;
        start32 = 1'b0;
        test_reset();
        test_frame(0);
        test_frame(5);
        test_back_to_back();
        test_reset_mid();
        test_big();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
